// File: rtl/mole_scheduler.sv
// mole_scheduler -- game-flow controller for the whack-a-mole datapath.
//
// Turns the free-running pseudo-random value into timed mole appearances,
// resolves player hits against timeouts, and keeps score and miss count
// until the game ends.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   tick           1 ms enable strobe (one clk wide); every timer advances only on tick
//   start          level; starts a game from IDLE or GAME_OVER, ignored elsewhere
//   random_number  pseudo-random value, nominally 1..500 (clamped internally)
//   hit_valid      one-cycle pulse: player struck hole hit_pos
//   hit_pos        hole struck, qualified by hit_valid
//   mole_active    high while a mole is visible (registered from the SHOW state)
//   mole_pos       hole of the current or last mole; holds outside SHOW
//   score          hits this game, saturating at SCORE_MAX
//   misses         timeouts this game
//   hit_flash      one-cycle pulse on a successful hit
//   miss_flash     one-cycle pulse on a timeout
//   game_over      high in GAME_OVER
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: hit_valid/hit_pos is a fire-and-forget pulse with no ready.
// A pulse is consumed only in SHOW when hit_pos matches mole_pos; in every
// other case it is dropped without any side effect.
module mole_scheduler #(
    parameter int NUM_HOLES    = 9,
    parameter int SHOW_BASE_MS = 400,
    parameter int GAP_MS       = 200,
    parameter int MAX_MISSES   = 5,
    parameter int SCORE_MAX    = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] random_number,
    input  logic       hit_valid,
    input  logic [3:0] hit_pos,
    output logic       mole_active,
    output logic [3:0] mole_pos,
    output logic [9:0] score,
    output logic [3:0] misses,
    output logic       hit_flash,
    output logic       miss_flash,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_SHOW = 3'd2,
        S_HIT  = 3'd3,
        S_MISS = 3'd4,
        S_OVER = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] timer;
    logic [10:0] show_len;

    logic [9:0]  r_clamped;
    logic [3:0]  pos_raw;
    logic [3:0]  pos_new;
    logic [10:0] show_len_new;
    logic        gap_done;
    logic        show_done;
    logic        hit_ok;
    logic        start_game;

    // Clamp the random value into 1..500 before deriving position and length.
    always_comb begin
        if (random_number == 10'd0)
            r_clamped = 10'd1;
        else if (random_number > 10'd500)
            r_clamped = 10'd500;
        else
            r_clamped = random_number;
    end

    // mole_pos doubles as the previous-position register: it only changes
    // when a new mole is sampled, so it always holds the last mole's hole.
    assign pos_raw      = 4'(r_clamped % 10'(NUM_HOLES));
    assign pos_new      = (pos_raw != mole_pos)           ? pos_raw :
                          (pos_raw == 4'(NUM_HOLES - 1))  ? 4'd0    :
                                                            pos_raw + 4'd1;
    assign show_len_new = 11'(SHOW_BASE_MS) + {1'b0, r_clamped};

    assign gap_done   = tick && (timer == 11'(GAP_MS - 1));
    assign show_done  = tick && (timer == show_len - 11'd1);
    assign hit_ok     = hit_valid && (hit_pos == mole_pos);
    assign start_game = start && ((state == S_IDLE) || (state == S_OVER));
    assign state_dbg  = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_GAP;
            S_GAP:  if (gap_done) state_next = S_SHOW;
            // A hit on the timeout tick still counts as a hit.
            S_SHOW: begin
                if (hit_ok)
                    state_next = S_HIT;
                else if (show_done)
                    state_next = S_MISS;
            end
            S_HIT:  state_next = S_GAP;
            // misses was already incremented on entry to MISS.
            S_MISS: state_next = (misses == 4'(MAX_MISSES)) ? S_OVER : S_GAP;
            S_OVER: if (start) state_next = S_GAP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            show_len    <= '0;
            mole_active <= 1'b0;
            mole_pos    <= '0;
            score       <= '0;
            misses      <= '0;
            hit_flash   <= 1'b0;
            miss_flash  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state <= state_next;

            // Outputs are registered; flashes and game_over line up with the
            // cycle spent in the corresponding state.
            mole_active <= (state == S_SHOW);
            hit_flash   <= (state_next == S_HIT);
            miss_flash  <= (state_next == S_MISS);
            game_over   <= (state_next == S_OVER);

            // Every state change restarts the timer; only GAP and SHOW count.
            if (state_next != state)
                timer <= '0;
            else if (tick && ((state == S_GAP) || (state == S_SHOW)))
                timer <= timer + 11'd1;

            if ((state == S_GAP) && (state_next == S_SHOW)) begin
                mole_pos <= pos_new;
                show_len <= show_len_new;
            end

            if (start_game) begin
                score  <= '0;
                misses <= '0;
            end else begin
                if ((state_next == S_HIT) && (score != 10'(SCORE_MAX)))
                    score <= score + 10'd1;
                if (state_next == S_MISS)
                    misses <= misses + 4'd1;
            end
        end
    end

endmodule
